// File: rtl/uart_pkg.sv
// Shared UART constants: default data width, default FIFO depth and the occupancy width helper.
package uart_pkg;

    localparam int UART_W_DEFAULT          = 8;
    localparam int UART_DEPTH_LOG2_DEFAULT = 2;

    // The counter needs one more bit than the pointers so that DEPTH itself can be represented.
    function automatic int occ_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_ptr.sv
// Wrapping FIFO pointer. It wraps from 2**AW-1 back to 0 through natural overflow.
module uart_fifo_ptr #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + AW'(1);
        end
    end

endmodule

// File: rtl/uart_flag_fifo.sv
// Flag-style FIFO with first-word fall-through. flag means the head word is valid.
// The optional sticky overrun flag is built only when UART_FLAG_FIFO_OVR_EN is defined.
module uart_flag_fifo
    import uart_pkg::*;
#(
    parameter int W          = UART_W_DEFAULT,
    parameter int DEPTH_LOG2 = UART_DEPTH_LOG2_DEFAULT,
    parameter int AF_LEVEL   = (1 << DEPTH_LOG2) - 1
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                set_flag,
    input  logic                                clr_flag,
    input  logic [W-1:0]                        din,
    input  logic                                clr_overrun,
    output logic                                flag,
    output logic [W-1:0]                        dout,
    output logic                                full,
    output logic                                almost_full,
    output logic [occ_width(DEPTH_LOG2)-1:0]    count,
    output logic                                overrun
);

    localparam int             DEPTH   = 1 << DEPTH_LOG2;
    localparam int             CW      = occ_width(DEPTH_LOG2);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  AF_C    = CW'(AF_LEVEL);

    logic [W-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;

    // Handshake: a push is taken when set_flag=1 and there is room, where a pop in the same
    // cycle frees a slot even when full; a pop is taken when clr_flag=1 and flag=1, and
    // clr_flag on an empty FIFO is ignored.
    assign pop  = clr_flag && flag;
    assign push = set_flag && (!full || pop);

    assign flag        = (count != '0);
    assign full        = (count == DEPTH_C);
    assign almost_full = (count >= AF_C);
    assign dout        = mem[rd_ptr];

    uart_fifo_ptr #(.AW(DEPTH_LOG2)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (push),
        .ptr     (wr_ptr)
    );

    uart_fifo_ptr #(.AW(DEPTH_LOG2)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (pop),
        .ptr     (rd_ptr)
    );

    // Storage is deliberately left unreset; only the pointers and the count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

`ifdef UART_FLAG_FIFO_OVR_EN
    logic drop;
    assign drop = set_flag && full && !pop;

    // Set takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_clr_overrun;
    assign unused_clr_overrun = clr_overrun;
    assign overrun            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_flag_fifo.sv
// Self-checking bench for uart_flag_fifo: directed scenarios, then random traffic
// checked each cycle against a queue-based reference model.
module tb_uart_flag_fifo;

    localparam int W     = 8;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
`ifdef UART_FLAG_FIFO_OVR_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic           clk;
    logic           reset_n;
    logic           set_flag;
    logic           clr_flag;
    logic [W-1:0]   din;
    logic           clr_overrun;
    logic           flag;
    logic [W-1:0]   dout;
    logic           full;
    logic           almost_full;
    logic [DL2:0]   count;
    logic           overrun;

    int checks;
    int errors;
    logic [W-1:0] exp_q[$];
    bit           exp_ovr;

    uart_flag_fifo #(.W(W), .DEPTH_LOG2(DL2), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .set_flag    (set_flag),
        .clr_flag    (clr_flag),
        .din         (din),
        .clr_overrun (clr_overrun),
        .flag        (flag),
        .dout        (dout),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overrun     (overrun)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy and order come from the queue itself.
    task automatic model_edge(input logic sf, input logic cf, input logic [W-1:0] d, input logic co);
        bit pop_ok;
        bit push_ok;
        pop_ok  = cf && (exp_q.size() > 0);
        push_ok = sf && ((exp_q.size() < DEPTH) || pop_ok);
        if (pop_ok) void'(exp_q.pop_front());
        if (push_ok) exp_q.push_back(d);
        if (OVR) begin
            if (sf && !push_ok) exp_ovr = 1'b1;
            else if (co) exp_ovr = 1'b0;
        end
    endtask

    task automatic compare_all();
        int n;
        n = exp_q.size();
        check("flag", flag, n != 0);
        check("count", count, n);
        check("full", full, n == DEPTH);
        check("almost_full", almost_full, n >= AF);
        check("overrun", overrun, exp_ovr);
        if (n != 0) check("dout", dout, exp_q[0]);
    endtask

    // Driver: inputs are applied away from the edge, the model advances at the edge, outputs sampled 1 later.
    task automatic step(input logic sf, input logic cf, input logic [W-1:0] d, input logic co);
        set_flag    = sf;
        clr_flag    = cf;
        din         = d;
        clr_overrun = co;
        @(posedge clk);
        model_edge(sf, cf, d, co);
        #1;
        compare_all();
    endtask

    task automatic fill_1_to_4();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, W'(i), 1'b0);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_ovr = 1'b0;
        reset_n = 1'b0;
        set_flag = 1'b0;
        clr_flag = 1'b0;
        din = '0;
        clr_overrun = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flag", flag, 1'b0);
        check("reset_count", count, 0);
        check("reset_full", full, 1'b0);
        check("reset_af", almost_full, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        reset_n = 1'b1;

        // Single word round trip
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        check("single_flag", flag, 1'b1);
        check("single_dout", dout, 8'hA5);
        check("single_count", count, 1);
        step(1'b0, 1'b1, '0, 1'b0);
        check("single_pop_flag", flag, 1'b0);
        check("single_pop_count", count, 0);

        // Fill to full, thresholds, ordered drain
        step(1'b1, 1'b0, 8'h01, 1'b0);
        step(1'b1, 1'b0, 8'h02, 1'b0);
        check("af_below", almost_full, 1'b0);
        step(1'b1, 1'b0, 8'h03, 1'b0);
        check("af_at3", almost_full, 1'b1);
        check("full_at3", full, 1'b0);
        step(1'b1, 1'b0, 8'h04, 1'b0);
        check("full_at4", full, 1'b1);
        check("af_at4", almost_full, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", dout, W'(i));
            step(1'b0, 1'b1, '0, 1'b0);
        end
        check("drained_flag", flag, 1'b0);

        // Dropped push when full, then clear overrun
        fill_1_to_4();
        step(1'b1, 1'b0, 8'h55, 1'b0);
        check("drop_count", count, 4);
        check("drop_overrun", overrun, OVR);
        check("drop_head", dout, 8'h01);
        step(1'b0, 1'b0, '0, 1'b1);
        check("clr_overrun", overrun, 1'b0);

        // Full with simultaneous push and pop
        step(1'b1, 1'b1, 8'h66, 1'b0);
        check("fullpp_count", count, 4);
        check("fullpp_overrun", overrun, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, 1'b0);
        check("fullpp_last", dout, 8'h66);
        step(1'b0, 1'b1, '0, 1'b0);

        // Empty with simultaneous push and pop, then streaming across the wrap
        step(1'b1, 1'b1, 8'h77, 1'b0);
        check("emptypp_count", count, 1);
        check("emptypp_dout", dout, 8'h77);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, W'(8'h80 + i), 1'b0);
        check("wrap_dout", dout, 8'h89);
        drain();

        // Asynchronous reset with three words stored; push in the release cycle is accepted
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(8'hC0 + i), 1'b0);
        set_flag = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("async_rst_flag", flag, 1'b0);
        check("async_rst_count", count, 0);
        exp_q.delete();
        exp_ovr = 1'b0;
        #1;
        reset_n = 1'b1;
        step(1'b1, 1'b0, 8'h3C, 1'b0);
        check("post_rst_dout", dout, 8'h3C);
        drain();

        // Random traffic in phases biased toward filling, draining and balanced
        for (int ph = 0; ph < 6; ph++) begin
            int push_pct;
            int pop_pct;
            push_pct = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
            pop_pct  = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 80 : 50;
            for (int c = 0; c < 60; c++) begin
                step($urandom_range(99) < push_pct, $urandom_range(99) < pop_pct,
                     W'($urandom_range(255)), $urandom_range(9) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
